// File: rtl/prbs_sym_gen.sv
// prbs_sym_gen: Fibonacci LFSR pseudo-random bit source packed into
// SYM_BITS-wide symbols delivered over a valid/ready handshake, with an
// accepted-symbol counter and a one-cycle sequence-period marker.
// Optional feature macro: PRBS_ERR_INJECT_EN adds the err_inj input, which
// flips the bit written into the accumulator without disturbing the LFSR.
module prbs_sym_gen #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               SYM_BITS  = 4,
    parameter int               CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     seed_in,
    input  logic                 sym_ready,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                 err_inj,
`endif
    output logic                 sym_valid,
    output logic [SYM_BITS-1:0]  sym,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 period_done
);

    localparam int              BC_W    = $clog2(SYM_BITS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(SYM_BITS - 1);

    logic [WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]     seed_q, seed_d;
    logic [SYM_BITS-2:0]  acc_q, acc_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SYM_BITS-1:0]  sym_q, sym_d;
    logic                 sym_valid_q, sym_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 period_done_q, period_done_d;

    logic                 stall;
    logic                 step;
    logic                 accept;
    logic                 out_bit;
    logic                 acc_bit;
    logic                 fb;
    logic [WIDTH-1:0]     lfsr_next;
    logic [SYM_BITS-1:0]  acc_shift;
    logic                 sym_done;
    logic [WIDTH-1:0]     load_seed;

    // Handshake qualifiers and the LFSR/accumulator datapath for one step.
    always_comb begin
        stall     = sym_valid_q & ~sym_ready;
        step      = en & ~stall & ~load;
        accept    = sym_valid_q & sym_ready;
        out_bit   = lfsr_q[WIDTH-1];
        fb        = ^(lfsr_q & TAPS);
        lfsr_next = {lfsr_q[WIDTH-2:0], fb};
`ifdef PRBS_ERR_INJECT_EN
        acc_bit   = out_bit ^ err_inj;
`else
        acc_bit   = out_bit;
`endif
        acc_shift = {acc_q, acc_bit};
        sym_done  = step & (bit_cnt_q == BC_LAST);
        load_seed = (seed_in == '0) ? SEED : seed_in;
    end

    // Next-state: load overrides everything, otherwise step and handshake.
    always_comb begin
        lfsr_d        = lfsr_q;
        seed_d        = seed_q;
        acc_d         = acc_q;
        bit_cnt_d     = bit_cnt_q;
        sym_d         = sym_q;
        sym_valid_d   = sym_valid_q;
        cnt_d         = cnt_q;
        period_done_d = 1'b0;

        if (load) begin
            lfsr_d      = load_seed;
            seed_d      = load_seed;
            acc_d       = '0;
            bit_cnt_d   = '0;
            sym_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            if (accept) begin
                cnt_d       = cnt_q + CNT_WIDTH'(1);
                sym_valid_d = 1'b0;
            end
            if (step) begin
                lfsr_d        = lfsr_next;
                period_done_d = (lfsr_next == seed_q);
                if (sym_done) begin
                    sym_d       = acc_shift;
                    sym_valid_d = 1'b1;
                    acc_d       = '0;
                    bit_cnt_d   = '0;
                end else begin
                    acc_d     = acc_shift[SYM_BITS-2:0];
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q        <= SEED;
            seed_q        <= SEED;
            acc_q         <= '0;
            bit_cnt_q     <= '0;
            sym_q         <= '0;
            sym_valid_q   <= 1'b0;
            cnt_q         <= '0;
            period_done_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            seed_q        <= seed_d;
            acc_q         <= acc_d;
            bit_cnt_q     <= bit_cnt_d;
            sym_q         <= sym_d;
            sym_valid_q   <= sym_valid_d;
            cnt_q         <= cnt_d;
            period_done_q <= period_done_d;
        end
    end

    assign sym_valid   = sym_valid_q;
    assign sym         = sym_q;
    assign cnt         = cnt_q;
    assign period_done = period_done_q;

endmodule
